drum_audio_out: RTL and testbench
=================================

Name: drum_audio_out

Overview:
- Consumer end of the drum-column interface. Waits for the column array to finish an iteration, captures the center-node amplitude and converts it to a 32-bit audio sample.
- Pushes the sample to the audio FIFO over a valid/ready handshake.
- Issues the iteration_enable pulse that starts the next iteration, paced to the audio sample rate.
- Sits between the one_column array and the audio codec FIFO bridge.

Parameters:
- SAMPLE_DIV, 1042, clk cycles per audio sample (50 MHz / 48 kHz).
- AUDIO_SHIFT, 14, left shift that maps the 18-bit node value into the 32-bit sample. 18 + AUDIO_SHIFT must equal 32.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- column_done  input  1  high while the column array is idle in its iteration-done state.
- center_node  input  18  signed 1.17 center-node amplitude, valid while column_done=1.
- iteration_enable  output  1  one-cycle pulse that starts the next column iteration.
- audio_valid  output  1  sample available to the FIFO bridge.
- audio_ready  input  1  FIFO bridge accepts the sample this cycle.
- audio_left  output  32  left-channel sample.
- audio_right  output  32  right-channel sample, always equal to audio_left.
- sample_count  output  16  samples accepted by the FIFO, wraps at 16'hFFFF.
- overrun_count  output  16  ticks missed, saturates at 16'hFFFF.

Behaviour:
- Reset: on reset=0 at a clk edge, clear every output, tick counter, tick_pending and sample register; state <= WAIT_DONE. This applies mid-operation too: audio_valid drops the next cycle and no iteration_enable is issued.
- Tick counter: counts 0..SAMPLE_DIV-1 and wraps. tick=1 on the cycle count==SAMPLE_DIV-1.
- tick_pending: set on tick, cleared when iteration_enable fires. If tick and the clear occur in the same cycle, tick_pending stays 1. If tick occurs while tick_pending=1 and it is not being cleared, overrun_count increments (saturating).
- Sample conversion: sample_reg = {center_node, AUDIO_SHIFT zeros}, a signed 32-bit value. audio_left = audio_right = sample_reg.
- State machine:
  - WAIT_DONE: if column_done=1, go to CAPTURE.
  - CAPTURE (1 cycle): sample_reg <= center_node; go to PUSH.
  - PUSH: audio_valid=1. audio_left/right stay stable until the handshake completes. On audio_valid&&audio_ready, sample_count <= sample_count+1 and go to ARM. audio_valid deasserts the cycle after acceptance.
  - ARM: if tick_pending=1 (including a tick this cycle), iteration_enable=1 for exactly this cycle, clear tick_pending, go to HOLDOFF. Otherwise stay in ARM.
  - HOLDOFF (1 cycle): ignore column_done, which is still high this cycle; go to WAIT_DONE.
- iteration_enable is registered: high exactly one cycle per sample, never outside ARM.
- Latency:
  - column_done rise to audio_valid: 2 cycles.
  - Accept to iteration_enable: 1 cycle minimum if tick_pending is already set; otherwise waits for the next tick.
- FIFO stall in PUSH: remain in PUSH holding data; ticks accumulate into tick_pending and overrun_count.
- If column_done drops while in PUSH, the captured sample remains valid and is still pushed.

Test Plan:
- Reset hold then release, column_done=1, center_node=18'h08000, audio_ready=1:
  - audio_valid rises 2 cycles after column_done.
  - audio_left = audio_right = 32'h20000000.
  - sample_count=1.
  - iteration_enable pulses once at the first tick (cycle 1041 after release).
- center_node=18'h3FFFF (-1 LSB): sample = 32'hFFFFC000. center_node=18'h20000 (most negative): sample = 32'h80000000.
- Hold audio_ready=0 for 3*SAMPLE_DIV cycles, then assert:
  - data is stable throughout the stall.
  - overrun_count=2.
  - exactly one iteration_enable after acceptance.
  - sample_count=1.
- Steady state, column_done returns 10 cycles after each enable, audio_ready=1, run 100 samples:
  - iteration_enable period = exactly 1042 cycles.
  - sample_count=100, overrun_count=0.
- Assert reset=0 during PUSH with audio_valid=1:
  - next cycle audio_valid=0 and all counts are 0.
  - no iteration_enable until a fresh column_done cycle completes.
- Force tick on the same cycle the ARM state consumes tick_pending: tick_pending stays 1, and the next sample's enable fires immediately after its acceptance.

Source files
------------

// File: rtl/drum_audio_out.sv
// drum_audio_out: consumer end of the drum-column interface.
// Captures the center-node amplitude after each column iteration, pushes it
// to the audio FIFO as a 32-bit sample and paces the next iteration to the
// audio sample rate.
module drum_audio_out #(
    parameter int SAMPLE_DIV  = 1042,
    parameter int AUDIO_SHIFT = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        column_done,
    input  logic [17:0] center_node,
    output logic        iteration_enable,
    output logic        audio_valid,
    input  logic        audio_ready,
    output logic [31:0] audio_left,
    output logic [31:0] audio_right,
    output logic [15:0] sample_count,
    output logic [15:0] overrun_count
);

    localparam int CW = $clog2(SAMPLE_DIV);

    typedef enum logic [2:0] {
        WAIT_DONE,
        CAPTURE,
        PUSH,
        ARM,
        HOLDOFF
    } state_t;

    state_t        state;
    logic [CW-1:0] tick_cnt;
    logic          tick_pending;
    logic [31:0]   sample_reg;
    logic          tick;
    logic          fire;

    assign tick = (tick_cnt == CW'(SAMPLE_DIV - 1));
    // ARM may consume either a tick already banked or one arriving right now
    assign fire = (state == ARM) && (tick_pending || tick);

    assign audio_left  = sample_reg;
    assign audio_right = sample_reg;

    // free-running sample-rate divider
    always_ff @(posedge clk) begin
        if (!reset)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + CW'(1);
    end

    // bank one tick for ARM; extra ticks while one is banked count as overruns
    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_pending  <= 1'b0;
            overrun_count <= '0;
        end else begin
            if (fire)
                // a fresh tick landing as the banked one is used stays banked
                tick_pending <= tick_pending & tick;
            else if (tick)
                tick_pending <= 1'b1;

            if (tick && tick_pending && !fire && overrun_count != 16'hFFFF)
                overrun_count <= overrun_count + 16'd1;
        end
    end

    // capture / push / arm sequencing with registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= WAIT_DONE;
            sample_reg       <= '0;
            audio_valid      <= 1'b0;
            iteration_enable <= 1'b0;
            sample_count     <= '0;
        end else begin
            iteration_enable <= 1'b0;
            case (state)
                WAIT_DONE: begin
                    if (column_done)
                        state <= CAPTURE;
                end
                CAPTURE: begin
                    sample_reg  <= {center_node, {AUDIO_SHIFT{1'b0}}};
                    audio_valid <= 1'b1;
                    state       <= PUSH;
                end
                PUSH: begin
                    // data holds until accepted, even if column_done drops
                    if (audio_ready) begin
                        audio_valid  <= 1'b0;
                        sample_count <= sample_count + 16'd1;
                        state        <= ARM;
                    end
                end
                ARM: begin
                    if (fire) begin
                        iteration_enable <= 1'b1;
                        state            <= HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    // column_done is still high from the previous iteration
                    state <= WAIT_DONE;
                end
                default: state <= WAIT_DONE;
            endcase
        end
    end

endmodule

// File: tb/tb_drum_audio_out.sv
// Testbench for drum_audio_out: directed and randomized samples checked every
// cycle against a behavioural model of the sample/tick rules.
module tb_drum_audio_out;

    localparam int SAMPLE_DIV  = 1042;
    localparam int AUDIO_SHIFT = 14;

    logic        clk = 1'b0;
    logic        reset;
    logic        column_done;
    logic [17:0] center_node;
    logic        iteration_enable;
    logic        audio_valid;
    logic        audio_ready;
    logic [31:0] audio_left;
    logic [31:0] audio_right;
    logic [15:0] sample_count;
    logic [15:0] overrun_count;

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;

    drum_audio_out #(.SAMPLE_DIV(SAMPLE_DIV), .AUDIO_SHIFT(AUDIO_SHIFT)) dut (
        .clk              (clk),
        .reset            (reset),
        .column_done      (column_done),
        .center_node      (center_node),
        .iteration_enable (iteration_enable),
        .audio_valid      (audio_valid),
        .audio_ready      (audio_ready),
        .audio_left       (audio_left),
        .audio_right      (audio_right),
        .sample_count     (sample_count),
        .overrun_count    (overrun_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // m_n: cycles since reset release; a tick falls on every SAMPLE_DIV-th one.
    // m_where: 0 idle, 1 grabbing, 2 offering, 3 waiting for a tick, 4 cooldown
    int          m_n;
    int          m_where;
    bit          m_valid;
    bit          m_en;
    bit          m_banked;
    bit          m_tk;
    bit          m_used;
    logic [31:0] m_sample;
    logic [15:0] m_cnt;
    int          m_ovr;

    always @(posedge clk) begin
        if (!reset) begin
            m_n = 0; m_where = 0; m_valid = 0; m_en = 0; m_banked = 0;
            m_sample = '0; m_cnt = '0; m_ovr = 0;
        end else begin
            m_tk   = ((m_n % SAMPLE_DIV) == SAMPLE_DIV - 1);
            m_n    = m_n + 1;
            m_en   = 0;
            m_used = 0;
            case (m_where)
                0: if (column_done) m_where = 1;
                1: begin
                    m_sample = 32'(int'($signed(center_node)) * (1 << AUDIO_SHIFT));
                    m_valid  = 1;
                    m_where  = 2;
                end
                2: if (audio_ready) begin
                    m_valid = 0;
                    m_cnt   = m_cnt + 16'd1;
                    m_where = 3;
                end
                3: if (m_banked || m_tk) begin
                    m_en = 1; m_used = 1; m_where = 4;
                end
                default: m_where = 0;
            endcase
            if (m_tk && m_banked && !m_used && m_ovr < 65535) m_ovr = m_ovr + 1;
            if (m_used) m_banked = m_banked && m_tk;
            else        m_banked = m_banked || m_tk;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance one cycle and compare every output with the model
    task automatic step();
        @(negedge clk);
        edge_cnt++;
        chk("valid",   32'(audio_valid),      32'(m_valid));
        chk("enable",  32'(iteration_enable), 32'(m_en));
        chk("left",    audio_left,            m_sample);
        chk("right",   audio_right,           m_sample);
        chk("count",   32'(sample_count),     32'(m_cnt));
        chk("overrun", 32'(overrun_count),    32'(m_ovr[15:0]));
    endtask

    task automatic do_reset();
        reset = 1'b0; column_done = 1'b0; audio_ready = 1'b0; center_node = '0;
        repeat (3) step();
        chk("rst_valid", 32'(audio_valid), 32'd0);
        chk("rst_count", 32'(sample_count), 32'd0);
        reset = 1'b1;
        edge_cnt = 0;
    endtask

    // one full sample: column done after gap, FIFO stalled for stall cycles
    task automatic run_sample(input logic [17:0] node, input int gap, input int stall,
                              output int acc_e, output int en_e);
        int lat;
        int k;
        repeat (gap) step();
        column_done = 1'b1;
        center_node = node;
        lat = 0;
        while (!audio_valid && lat < 8) begin step(); lat++; end
        chk("latency", 32'(lat), 32'd2);
        repeat (stall) step();
        audio_ready = 1'b1;
        k = 0;
        do begin step(); k++; end while (audio_valid && k < 4);
        acc_e = edge_cnt - 1;
        audio_ready = 1'b0;
        k = 0;
        while (!iteration_enable && k < 3 * SAMPLE_DIV) begin step(); k++; end
        chk("en_seen", 32'(iteration_enable), 32'd1);
        en_e = edge_cnt - 1;
        // column stays done through the cooldown cycle, then drops
        step();
        column_done = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc_e, en_e, prev_en, n_done;
        reset = 1'b0; column_done = 1'b0; audio_ready = 1'b0; center_node = '0;

        // basic sample and first enable on the first tick
        do_reset();
        run_sample(18'h08000, 0, 0, acc_e, en_e);
        chk("s1_left",  audio_left,  32'h20000000);
        chk("s1_right", audio_right, 32'h20000000);
        chk("s1_count", 32'(sample_count), 32'd1);
        chk("s1_en",    32'(en_e), 32'(SAMPLE_DIV - 1));
        prev_en = en_e;

        run_sample(18'h3FFFF, 10, 0, acc_e, en_e);
        chk("neg1_left", audio_left, 32'hFFFFC000);
        chk("period", 32'(en_e - prev_en), 32'(SAMPLE_DIV));
        prev_en = en_e;
        run_sample(18'h20000, 10, 0, acc_e, en_e);
        chk("min_left", audio_left, 32'h80000000);
        chk("period", 32'(en_e - prev_en), 32'(SAMPLE_DIV));
        prev_en = en_e;

        // steady state, random amplitudes
        n_done = 3;
        for (int i = 0; i < 15; i++) begin
            run_sample(18'($urandom), 10, 0, acc_e, en_e);
            chk("period", 32'(en_e - prev_en), 32'(SAMPLE_DIV));
            prev_en = en_e;
            n_done++;
        end
        chk("steady_count", 32'(sample_count), 32'(n_done));
        chk("steady_ovr",   32'(overrun_count), 32'd0);

        // long FIFO stall: three ticks, one banked and two overruns
        do_reset();
        run_sample(18'h0ABCD, 0, 3 * SAMPLE_DIV, acc_e, en_e);
        chk("stall_ovr",   32'(overrun_count), 32'd2);
        chk("stall_count", 32'(sample_count), 32'd1);
        chk("stall_en",    32'(en_e - acc_e), 32'd1);
        chk("stall_left",  audio_left, 32'(int'($signed(18'h0ABCD)) * (1 << AUDIO_SHIFT)));

        // ARM uses the banked tick on a tick cycle: the new tick stays banked
        do_reset();
        run_sample(18'h01234, 0, 2 * SAMPLE_DIV - 4, acc_e, en_e);
        chk("ft_acc", 32'(acc_e), 32'(2 * SAMPLE_DIV - 2));
        chk("ft_en",  32'(en_e),  32'(2 * SAMPLE_DIV - 1));
        run_sample(18'h35555, 10, 0, acc_e, en_e);
        chk("ft_next_en", 32'(en_e - acc_e), 32'd1);
        run_sample(18'h00001, 10, 0, acc_e, en_e);
        chk("ft_tick_en", 32'(en_e), 32'(3 * SAMPLE_DIV - 1));

        // reset while offering a sample
        do_reset();
        column_done = 1'b1;
        center_node = 18'h12345;
        for (int i = 0; i < 8 && !audio_valid; i++) step();
        chk("pre_rst_valid", 32'(audio_valid), 32'd1);
        reset = 1'b0;
        step();
        chk("mid_rst_valid", 32'(audio_valid), 32'd0);
        chk("mid_rst_count", 32'(sample_count), 32'd0);
        chk("mid_rst_ovr",   32'(overrun_count), 32'd0);
        column_done = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        edge_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("no_en_after_rst", 32'(iteration_enable), 32'd0);
        end
        run_sample(18'h12345, 0, 0, acc_e, en_e);
        chk("rst_en", 32'(en_e), 32'(SAMPLE_DIV - 1));

        // random gaps and stalls, model tracks overruns and banking
        for (int i = 0; i < 6; i++)
            run_sample(18'($urandom), 1 + int'($urandom_range(40)),
                       int'($urandom_range(1500)), acc_e, en_e);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
